// File: rtl/rv_isa_pkg.sv
// rv_isa_pkg: RV32I instruction formats and major-opcode constants, shared with the ImmGen side.
package rv_isa_pkg;
  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} fmt_e;
  localparam logic [4:0] OP_LOAD     = 5'd0;
  localparam logic [4:0] OP_MISC_MEM = 5'd3;
  localparam logic [4:0] OP_OP_IMM   = 5'd4;
  localparam logic [4:0] OP_AUIPC    = 5'd5;
  localparam logic [4:0] OP_STORE    = 5'd8;
  localparam logic [4:0] OP_LUI      = 5'd13;
  localparam logic [4:0] OP_BRANCH   = 5'd24;
  localparam logic [4:0] OP_JALR     = 5'd25;
  localparam logic [4:0] OP_JAL      = 5'd27;
  localparam logic [4:0] OP_SYSTEM   = 5'd28;
  function automatic fmt_e fmt_of(logic [4:0] op);
    return op == OP_STORE ? FMT_S :
           op == OP_BRANCH ? FMT_B :
           (op == OP_AUIPC || op == OP_LUI) ? FMT_U :
           op == OP_JAL ? FMT_J :
           (op == OP_LOAD || op == OP_MISC_MEM || op == OP_OP_IMM ||
            op == OP_JALR || op == OP_SYSTEM) ? FMT_I : FMT_R;
  endfunction
endpackage

// File: rtl/inst_enc_fifo2.sv
// inst_enc_fifo2: 2-entry FIFO with registered in_ready and registered head output.
module inst_enc_fifo2 #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] din,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] dout
);
  logic [1:0] cnt, cnt_n;
  logic [W-1:0] m0, m1;
  logic push, pop;
  assign push = in_valid && in_ready;
  assign pop = out_valid && out_ready;
  assign out_valid = cnt != 2'd0;
  assign dout = m0;
  assign cnt_n = cnt + {1'b0, push} - {1'b0, pop};
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= 2'd0;
      in_ready <= 1'b0;
      m0 <= '0;
      m1 <= '0;
    end else begin
      cnt <= cnt_n;
      in_ready <= cnt_n < 2'd2;
      if (pop && cnt == 2'd2)
        m0 <= m1;
      else if (push && (cnt == 2'd0 || pop))
        m0 <= din;
      if (push && cnt == 2'd1 && !pop)
        m1 <= din;
    end
  end
endmodule

// File: rtl/inst_encoder.sv
// inst_encoder: packs RV32I fields into an instruction word behind a 2-entry output FIFO.
// Immediate range checking is built only when INST_ENC_RANGE_CHECK_EN is defined.
module inst_encoder
  import rv_isa_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        InValid,
  output logic        InReady,
  input  logic [6:0]  Opcode,
  input  logic [4:0]  Rd,
  input  logic [4:0]  Rs1,
  input  logic [4:0]  Rs2,
  input  logic [2:0]  Funct3,
  input  logic [6:0]  Funct7,
  input  logic [31:0] Immediate,
  output logic        OutValid,
  input  logic        OutReady,
  output logic [31:0] Instruction,
  output logic        ImmError
);
  fmt_e fmt;
  logic [31:0] word;
  logic imm_err;
  logic [31:0] i;
  assign i = Immediate;
  assign fmt = fmt_of(Opcode[6:2]);
  always_comb begin
    word = fmt == FMT_I ? {i[11:0], Rs1, Funct3, Rd, Opcode} :
           fmt == FMT_S ? {i[11:5], Rs2, Rs1, Funct3, i[4:0], Opcode} :
           fmt == FMT_B ? {i[12], i[10:5], Rs2, Rs1, Funct3, i[4:1], i[11], Opcode} :
           fmt == FMT_U ? {i[31:12], Rd, Opcode} :
           fmt == FMT_J ? {i[20], i[10:1], i[11], i[19:12], Rd, Opcode} :
                          {Funct7, Rs2, Rs1, Funct3, Rd, Opcode};
  end
`ifdef INST_ENC_RANGE_CHECK_EN
  logic eq11, eq12, eq20;
  assign eq11 = &i[31:11] || ~|i[31:11];
  assign eq12 = &i[31:12] || ~|i[31:12];
  assign eq20 = &i[31:20] || ~|i[31:20];
  always_comb begin
    imm_err = (fmt == FMT_I || fmt == FMT_S) ? !eq11 :
              fmt == FMT_B ? (!eq12 || i[0]) :
              fmt == FMT_J ? (!eq20 || i[0]) :
              fmt == FMT_U ? |i[11:0] : 1'b0;
  end
`else
  assign imm_err = 1'b0;
`endif
  inst_enc_fifo2 #(.W(33)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (InValid),
    .in_ready  (InReady),
    .din       ({imm_err, word}),
    .out_valid (OutValid),
    .out_ready (OutReady),
    .dout      ({ImmError, Instruction})
  );
endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder: scoreboard bench; expected words are queued at acceptance and checked by a monitor.
module tb_inst_encoder;
  logic clk = 1'b0, rst_n = 1'b0, InValid = 1'b0, OutReady = 1'b1;
  logic InReady, OutValid, ImmError;
  logic [6:0] Opcode = '0, Funct7 = '0;
  logic [4:0] Rd = '0, Rs1 = '0, Rs2 = '0;
  logic [2:0] Funct3 = '0;
  logic [31:0] Immediate = '0, Instruction;
  logic [32:0] q[$];
  int checks = 0, errors = 0;
`ifdef INST_ENC_RANGE_CHECK_EN
  localparam logic CK = 1'b1;
`else
  localparam logic CK = 1'b0;
`endif

  inst_encoder dut (
    .clk(clk), .rst_n(rst_n), .InValid(InValid), .InReady(InReady),
    .Opcode(Opcode), .Rd(Rd), .Rs1(Rs1), .Rs2(Rs2), .Funct3(Funct3), .Funct7(Funct7),
    .Immediate(Immediate), .OutValid(OutValid), .OutReady(OutReady),
    .Instruction(Instruction), .ImmError(ImmError)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (OutValid && OutReady) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_unexpected: got %h expected nothing", {ImmError, Instruction});
      end else
        chk("out_word", {ImmError, Instruction}, q.pop_front());
    end
  end

  task automatic set_fields(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                            input logic [31:0] imm);
    Opcode = op; Rd = rd; Rs1 = rs1; Rs2 = rs2; Funct3 = f3; Funct7 = f7; Immediate = imm;
  endtask

  // Called at posedge+#1; holds InValid until InReady shows the next edge accepts.
  task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] imm, input logic [31:0] ins, input logic err);
    int n = 0;
    set_fields(op, rd, rs1, rs2, f3, f7, imm);
    InValid = 1'b1;
    while (!InReady && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!InReady) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got InReady=0 expected 1");
    end else begin
      q.push_back({err, ins});
      @(posedge clk); #1;
    end
    InValid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outvalid", {32'd0, OutValid}, 33'd0);
    chk("rst_inready", {32'd0, InReady}, 33'd0);
    chk("rst_instr", {ImmError, Instruction}, 33'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("inready_after_rst", {32'd0, InReady}, 33'd1);
    chk("idle_outvalid", {32'd0, OutValid}, 33'd0);
    send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h00500093, 1'b0);
    chk("latency1", {32'd0, OutValid}, 33'd1);
    send(7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 32'h0020A423, 1'b0);
    send(7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd4, 32'hFFDFF06F, 1'b0);
    send(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 32'h123452B7, 1'b0);
    send(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3, 32'h00208163, CK);
    send(7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800, 32'h80000013, CK);
    send(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'hDEADBEEF, 32'h402081B3, 1'b0);
    send(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1, 32'h000002B7, CK);
    send(7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00100000, 32'h8000006F, CK);
    send(7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'hFFFFF800, 32'h8020A023, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    // Backpressure: two accepted, third waits, then order is preserved.
    OutReady = 1'b0;
    send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 32'h00100093, 1'b0);
    send(7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, 32'h00200113, 1'b0);
    chk("full_inready", {32'd0, InReady}, 33'd0);
    set_fields(7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
    InValid = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      chk("wait_inready", {32'd0, InReady}, 33'd0);
      chk("hold_head", {ImmError, Instruction}, {1'b0, 32'h00100093});
    end
    OutReady = 1'b1;
    @(posedge clk); #1;
    chk("pop_full_no_accept", {32'd0, InReady}, 33'd1);
    send(7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 32'h00300193, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("drain_empty", {32'd0, OutValid}, 33'd0);
    // Reset with two words buffered: both are discarded.
    OutReady = 1'b0;
    send(7'h13, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4, 32'h00400213, 1'b0);
    send(7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h00500293, 1'b0);
    rst_n = 1'b0;
    q.delete();
    @(posedge clk); #1;
    chk("midrst_outvalid", {32'd0, OutValid}, 33'd0);
    chk("midrst_inready", {32'd0, InReady}, 33'd0);
    rst_n = 1'b1;
    OutReady = 1'b1;
    @(posedge clk); #1;
    chk("rerst_inready", {32'd0, InReady}, 33'd1);
    chk("rerst_outvalid", {32'd0, OutValid}, 33'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", {1'b0, 32'(q.size())}, 33'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/inst_encoder.md
INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-003 SHALL have port InValid, input, 1 bit: an input field set is offered.
REQ-004 SHALL have port InReady, output, 1 bit: the block accepts the input field set this cycle.
REQ-005 SHALL have ports Opcode (input, 7 bits), Rd (input, 5), Rs1 (input, 5), Rs2 (input, 5), Funct3 (input, 3) and Funct7 (input, 7): the instruction fields.
REQ-006 SHALL have port Immediate, input, 32 bits: the sign-extended immediate value to pack.
REQ-007 SHALL have port OutValid, output, 1 bit: Instruction is valid.
REQ-008 SHALL have port OutReady, input, 1 bit: the consumer takes Instruction this cycle.
REQ-009 SHALL have port Instruction, output, 32 bits: the encoded RV32I word.
REQ-010 SHALL have port ImmError, output, 1 bit: the Immediate was not representable; qualified by OutValid.

Function
REQ-011 SHALL transfer an input when InValid and InReady are both 1, and an output when OutValid and OutReady are both 1.
REQ-012 SHALL select the format from Opcode[6:2] as follows: 8=S, 24=B, 5 and 13=U, 27=J, 0/3/4/25/28=I, any other value=R.
REQ-013 SHALL always place Opcode in bits 6:0, Rd in 11:7 (R/I/U/J), Funct3 in 14:12 (R/I/S/B), Rs1 in 19:15 (R/I/S/B), Rs2 in 24:20 (R/S/B) and Funct7 in 31:25 (R).
REQ-014 SHALL pack the immediate as follows:
- I: Imm[11:0] into bits 31:20.
- S: Imm[11:5] into 31:25 and Imm[4:0] into 11:7.
- B: Imm[12|10:5] into 31:25 and Imm[4:1|11] into 11:7.
- U: Imm[31:12] into 31:12.
- J: Imm[20|10:1|11|19:12] into 31:12.
REQ-015 SHALL compute range errors as follows:
- I/S: error unless Imm[31:11] are all equal.
- B: error unless Imm[31:12] are all equal and Imm[0]=0.
- J: error unless Imm[31:20] are all equal and Imm[0]=0.
- U: error unless Imm[11:0]=0.
- R: never an error.
REQ-016 SHALL still emit the truncated encoding when ImmError=1; an error never drops a word.
REQ-017 SHALL buffer results in a 2-entry FIFO; latency from input accept to OutValid is exactly 1 cycle when the FIFO is empty.
REQ-018 SHALL drive InReady from a register; InReady=1 iff fewer than 2 entries are held.
REQ-019 SHALL, on a simultaneous accept and pop with 1 entry held, keep the count at 1 and present the new word next cycle.
REQ-020 SHALL, when full (InReady=0), not accept an input even if a pop occurs that cycle; InReady returns to 1 the next cycle.
REQ-021 SHALL emit words in strict acceptance order.
REQ-022 SHALL hold Instruction and ImmError stable while OutValid=1 and OutReady=0.

Reset
REQ-023 SHALL, while rst_n=0 at a clock edge, drive OutValid=0, Instruction=0, ImmError=0, InReady=0 and an empty FIFO.
REQ-024 SHALL drive InReady=1 on the first edge after rst_n returns to 1.
REQ-025 SHALL discard any buffered words when reset is asserted mid-operation.

Configuration
REQ-026 SHALL implement the REQ-015 checks only when INST_ENC_RANGE_CHECK_EN is defined; when it is undefined, ImmError SHALL be constant 0 and no check logic SHALL be present.

Structure
REQ-027 SHALL take the format enumeration (FMT_R/I/S/B/U/J) and the Opcode[6:2] constants from the shared package rv_isa_pkg, which ImmGen-side code also uses.
REQ-028 SHALL implement the 2-entry buffer as sub-module inst_enc_fifo2, parameterised by width (33 bits: Instruction plus ImmError).

Verification
REQ-029 SHALL cover: ADDI, Opcode=0x13, Rd=1, Rs1=0, Funct3=0, Imm=5 -> Instruction=0x00500093, ImmError=0, 1 cycle latency.
REQ-030 SHALL cover: SW, Opcode=0x23, Funct3=2, Rs1=1, Rs2=2, Imm=8 -> 0x0020A423.
REQ-031 SHALL cover: JAL, Opcode=0x6F, Rd=0, Imm=-4 -> 0xFFDFF06F; LUI, Opcode=0x37, Rd=5, Imm=0x12345000 -> 0x123452B7.
REQ-032 SHALL cover, with INST_ENC_RANGE_CHECK_EN defined: BEQ with Imm=3 -> ImmError=1; ADDI with Imm=0x800 -> ImmError=1 and Instruction=0x80000013; without the macro both -> ImmError=0.
REQ-033 SHALL cover: OutReady=0 for 4 cycles while 3 inputs are offered -> 2 are accepted, InReady=0 after the second, the third waits; when OutReady=1, words appear in order.
REQ-034 SHALL cover: rst_n=0 for 1 cycle while 2 words are buffered -> OutValid=0 the next cycle, nothing emitted, InReady=1 one cycle after release.
